mac_dot_sequencer: RTL and testbench
====================================

# mac_dot_sequencer

Operand sequencer and accumulator controller that drives the pre-add/multiply/add MAC block (`out = a*(d+b)+c`, two-register `a` path, one-register `b`/`c`/`d` path, advancing only when all four valids are high). For an N-element vector it reads weights and pixels from two synchronous-read memories, streams them into the MAC with the `a`/`b` skew the MAC pipeline requires, and feeds MAC `out` back on `c` as two interleaved partial sums. It then combines the two partial sums into one dot-product result. It sits between the layer controller and the MAC in the neuron datapath.

## Interface
- `NO_OF_BITS`, 16, operand width; result width is 2*NO_OF_BITS.
- `ADDR_BITS`, 10, memory address width; maximum vector length is 2^ADDR_BITS.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: job request, sampled only in IDLE.
- `length` in ADDR_BITS+1: N, captured at start; values above 2^ADDR_BITS saturate to 2^ADDR_BITS.
- `w_addr`, `w_rd_en` out ADDR_BITS, 1: weight memory read; data returns the next cycle.
- `w_rdata` in NO_OF_BITS: weight memory data.
- `x_addr`, `x_rd_en` out ADDR_BITS, 1: pixel memory read; data returns the next cycle.
- `x_rdata` in NO_OF_BITS: pixel memory data.
- `a`, `b`, `c`, `d` out NO_OF_BITS (`c` 2*NO_OF_BITS, truncated to NO_OF_BITS at the MAC port): MAC operands.
- `a_valid`, `b_valid`, `c_valid`, `d_valid` out 1 each: always driven identically.
- `mac_out` in 2*NO_OF_BITS: MAC `out`. MAC `out_ready` is not used.
- `result` out 2*NO_OF_BITS: registered dot product.
- `result_valid` out 1: one-cycle pulse.
- `busy` out 1: high outside IDLE.

## Operation
- States: IDLE, PREFETCH, STREAM, FINISH.
- IDLE:
  - `start`=1 with N≥1 goes to PREFETCH.
  - `start`=1 with N=0 goes to FINISH with the forced-zero flag set.
- PREFETCH (1 cycle): `w_addr`=0, `w_rd_en`=1.
- STREAM, cycles j=0..N+1 (N+2 cycles). Every STREAM cycle is one MAC transfer: all valids are 1.
  - `a` = w_rdata (w_j) if j<N, else 0.
  - `b` = x_rdata (x_{j-1}) if 1≤j≤N, else 0.
  - `d` = 0.
  - `c` = mac_out if j≥3, else 0.
  - `w_addr`=j+1, `w_rd_en`=(j+1<N).
  - `x_addr`=j, `x_rd_en`=(j<N).
  - Result: even and odd partial-sum chains. Product w_k·x_k appears on mac_out after the transfer j=k+2.
- At the edge ending STREAM cycle j=N+1: `hold` <= mac_out (even/odd chain ending at N-2; 0 when N=1). Then go to FINISH.
- FINISH (1 cycle): at its edge `result` <= hold + mac_out (or 0 if forced-zero), `result_valid` <= 1, then go to IDLE.
- Arithmetic is unsigned, mod 2^(2·NO_OF_BITS).
- The garbage product on MAC transfer 0 is 0 by construction (b=d=c=0), so stale MAC registers never affect results.
- `start` while busy is ignored. Start is accepted in the same cycle `result_valid` is high.

## Timing
- Reset values: all outputs 0, state IDLE, `hold`=0, counters=0.
- For `start` sampled in cycle 0 with N≥1:
  - PREFETCH in cycle 1.
  - STREAM in cycles 2..N+3.
  - FINISH in cycle N+4.
  - `result_valid` in cycle N+5.
  - `busy` high in cycles 1..N+4.
- N=0: FINISH in cycle 1, `result_valid` in cycle 2, `result`=0.
- Valids are high for exactly N+2 consecutive cycles per job and low otherwise.
- `result` holds its value until the next FINISH.
- Reset mid-operation: the next cycle is IDLE with all outputs 0; no `result_valid` is emitted.

## Structure
- Shared header `mac_defs.vh`: default NO_OF_BITS, MAC_PIPE_DEPTH=2, state encodings, and the c-feedback start index (3).
- No sub-module. The MAC is instantiated beside this block at neuron top level.

## Test plan
- N=1, w={3}, x={5} -> result=15, `result_valid` in cycle 6, valids high cycles 2-4.
- N=4, w={1,2,3,4}, x={10,20,30,40} -> 300; valids high exactly 6 consecutive cycles; addresses sequence correctly.
- N=0 -> result=0 in cycle 2; no valid or rd_en asserted.
- N=2, w=x={0xFFFF,0xFFFF} -> 0xFFFC0002 (wrap).
- N=8, reset in STREAM cycle 3 -> all valids and busy low next cycle, no pulse. Then N=2, w={7,1}, x={6,2} -> 44.
- `start` held high continuously with N=3, w={1,1,1}, x={2,2,2} -> 6. The second job is accepted in the `result_valid` cycle and also gives 6.

Source files
------------

// File: rtl/mac_dot_sequencer_pkg.sv
// Shared definitions for the MAC dot-product sequencer: default widths, MAC
// pipeline geometry, FSM state encodings and the job-length saturation helper.
package mac_dot_sequencer_pkg;

  localparam int DEFAULT_NO_OF_BITS = 16;
  localparam int DEFAULT_ADDR_BITS  = 10;

  // The MAC delays `a` by two registers and `b`/`c`/`d` by one, so a product
  // can first be fed back on `c` one transfer after the pipe fills.
  localparam int MAC_PIPE_DEPTH   = 2;
  localparam int C_FEEDBACK_START = MAC_PIPE_DEPTH + 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREFETCH = 2'd1;
  localparam logic [1:0] ST_STREAM   = 2'd2;
  localparam logic [1:0] ST_FINISH   = 2'd3;

  // Requested lengths beyond the addressable memory depth are clipped to it.
  function automatic int unsigned sat_length(input int unsigned req,
                                             input int unsigned addr_bits);
    int unsigned depth;
    depth = 32'd1 << addr_bits;
    return (req > depth) ? depth : req;
  endfunction

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Bundle of job control, weight/pixel memory read ports, MAC operand ports and
// result signals seen by the dot-product sequencer.
interface mac_dot_sequencer_if
  import mac_dot_sequencer_pkg::*;
#(
  parameter int NO_OF_BITS = DEFAULT_NO_OF_BITS,
  parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
);

  // Job control from the layer controller
  logic                      start;
  logic [ADDR_BITS:0]        length;

  // Weight and pixel memories (synchronous read, data one cycle later)
  logic [ADDR_BITS-1:0]      w_addr;
  logic                      w_rd_en;
  logic [NO_OF_BITS-1:0]     w_rdata;
  logic [ADDR_BITS-1:0]      x_addr;
  logic                      x_rd_en;
  logic [NO_OF_BITS-1:0]     x_rdata;

  // MAC operands; `c` carries a full-width partial sum, the MAC keeps its low half
  logic [NO_OF_BITS-1:0]     a;
  logic [NO_OF_BITS-1:0]     b;
  logic [2*NO_OF_BITS-1:0]   c;
  logic [NO_OF_BITS-1:0]     d;
  logic                      a_valid;
  logic                      b_valid;
  logic                      c_valid;
  logic                      d_valid;
  logic [2*NO_OF_BITS-1:0]   mac_out;

  // Job result
  logic [2*NO_OF_BITS-1:0]   result;
  logic                      result_valid;
  logic                      busy;

  modport master (
    input  start, length, w_rdata, x_rdata, mac_out,
    output w_addr, w_rd_en, x_addr, x_rd_en,
    output a, b, c, d, a_valid, b_valid, c_valid, d_valid,
    output result, result_valid, busy
  );

  modport slave (
    output start, length, w_rdata, x_rdata, mac_out,
    input  w_addr, w_rd_en, x_addr, x_rd_en,
    input  a, b, c, d, a_valid, b_valid, c_valid, d_valid,
    input  result, result_valid, busy
  );

endinterface

// File: rtl/mac_dot_sequencer.sv
// Streams N weight/pixel pairs into the pre-add/multiply/add MAC as two
// interleaved partial-sum chains, then adds the chains into one dot product.
module mac_dot_sequencer
  import mac_dot_sequencer_pkg::*;
#(
  parameter int NO_OF_BITS = DEFAULT_NO_OF_BITS,
  parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
) (
  input logic                 clk,
  input logic                 reset,
  mac_dot_sequencer_if.master bus
);

  localparam int RW = 2 * NO_OF_BITS;
  // Counter must reach N+1 with N up to 2^ADDR_BITS.
  localparam int CW = ADDR_BITS + 2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] len;
  logic          zero_job;
  logic [RW-1:0] hold;
  logic [RW-1:0] result_q;
  logic          result_valid_q;
  logic          stream_last;

  assign stream_last = (cnt == len + CW'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      len            <= '0;
      zero_job       <= 1'b0;
      hold           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            len      <= CW'(sat_length(32'(bus.length), ADDR_BITS));
            cnt      <= '0;
            zero_job <= (bus.length == '0);
            state    <= (bus.length == '0) ? ST_FINISH : ST_PREFETCH;
          end
        end
        ST_PREFETCH: state <= ST_STREAM;
        ST_STREAM: begin
          if (stream_last) begin
            // mac_out here is the chain ending at N-2; the other chain lands next cycle.
            hold  <= bus.mac_out;
            cnt   <= '0;
            state <= ST_FINISH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_FINISH: begin
          result_q       <= zero_job ? '0 : hold + bus.mac_out;
          result_valid_q <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    bus.w_addr  = '0;
    bus.w_rd_en = 1'b0;
    bus.x_addr  = '0;
    bus.x_rd_en = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.c       = '0;
    bus.d       = '0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.c_valid = 1'b0;
    bus.d_valid = 1'b0;
    case (state)
      ST_PREFETCH: bus.w_rd_en = 1'b1;
      ST_STREAM: begin
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.c_valid = 1'b1;
        bus.d_valid = 1'b1;
        bus.w_addr  = ADDR_BITS'(cnt + CW'(1));
        bus.w_rd_en = (cnt + CW'(1) < len);
        bus.x_addr  = ADDR_BITS'(cnt);
        bus.x_rd_en = (cnt < len);
        // Pixel j-1 is paired with weight j to match the extra register on `a`.
        if (cnt < len)
          bus.a = bus.w_rdata;
        if ((cnt != '0) && (cnt <= len))
          bus.b = bus.x_rdata;
        if (cnt >= CW'(C_FEEDBACK_START))
          bus.c = bus.mac_out;
      end
      default: ;
    endcase
  end

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench: directed and random jobs against a plain dot-product
// reference, with behavioural memories and a MAC model around the sequencer.
module tb_mac_dot_sequencer;
  import mac_dot_sequencer_pkg::*;

  localparam int NB    = 16;
  localparam int AB    = 10;
  localparam int RW    = 2 * NB;
  localparam int LW    = AB + 1;
  localparam int DEPTH = 1 << AB;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mac_dot_sequencer_if #(.NO_OF_BITS(NB), .ADDR_BITS(AB)) bus ();

  mac_dot_sequencer #(.NO_OF_BITS(NB), .ADDR_BITS(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; read registers start with junk on purpose.
  logic [NB-1:0] wmem [DEPTH];
  logic [NB-1:0] xmem [DEPTH];
  logic [NB-1:0] w_q = 16'hA5A5;
  logic [NB-1:0] x_q = 16'h5A5A;

  always @(posedge clk) begin
    if (bus.w_rd_en) w_q <= wmem[bus.w_addr];
    if (bus.x_rd_en) x_q <= xmem[bus.x_addr];
  end
  assign bus.w_rdata = w_q;
  assign bus.x_rdata = x_q;

  // MAC: out = a*(d+b)+c, two registers on a, one on b/c/d, advancing only
  // when all valids are high. The feedback operand c is kept at full width so
  // the chained sums equal the mathematical dot product mod 2^32.
  logic [NB-1:0] a_r1  = 16'hBEEF;
  logic [NB-1:0] a_r2  = 16'hCAFE;
  logic [NB-1:0] b_r1  = 16'h1357;
  logic [NB-1:0] d_r1  = 16'h0F0F;
  logic [RW-1:0] c_r1  = 32'h0BAD_F00D;
  logic [RW-1:0] mac_q = 32'hDEAD_BEEF;
  logic          all_valid;

  assign all_valid = bus.a_valid & bus.b_valid & bus.c_valid & bus.d_valid;

  always @(posedge clk) begin
    if (all_valid) begin
      a_r1  <= bus.a;
      a_r2  <= a_r1;
      b_r1  <= bus.b;
      d_r1  <= bus.d;
      c_r1  <= bus.c;
      mac_q <= RW'(a_r2) * (RW'(d_r1) + RW'(b_r1)) + c_r1;
    end
  end
  assign bus.mac_out = mac_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] ref_dot(input int n);
    logic [RW-1:0] s;
    s = '0;
    for (int k = 0; k < n; k++) s += RW'(wmem[k]) * RW'(xmem[k]);
    return s;
  endfunction

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      wmem[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : NB'($urandom);
      xmem[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : NB'($urandom);
    end
  endtask

  // Starts at a falling edge (cycle 0 of the job) and returns at the falling
  // edge of the result_valid cycle, or after a bounded wait.
  task automatic run_job(input string tag, input int req_len, input bit hold_start,
                         output logic [RW-1:0] exp_res);
    int n;
    int vcount = 0, first_v = -1, last_v = -1, bcount = 0, rv_cyc = -1;
    int wr = 0, xr = 0, addr_err = 0, split = 0;
    logic [RW-1:0] res_seen = '0;
    n       = (req_len > DEPTH) ? DEPTH : req_len;
    exp_res = ref_dot(n);
    bus.start  = 1'b1;
    bus.length = LW'(req_len);
    @(negedge clk);
    if (!hold_start) bus.start = 1'b0;
    for (int cyc = 1; cyc <= n + 10; cyc++) begin
      if (bus.a_valid) begin
        vcount++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if ({bus.b_valid, bus.c_valid, bus.d_valid} != {3{bus.a_valid}}) split++;
      if (bus.busy) bcount++;
      if (bus.w_rd_en) begin
        if (bus.w_addr != AB'(wr)) addr_err++;
        wr++;
      end
      if (bus.x_rd_en) begin
        if (bus.x_addr != AB'(xr)) addr_err++;
        xr++;
      end
      if (bus.result_valid) begin
        rv_cyc   = cyc;
        res_seen = bus.result;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_result"},     res_seen, exp_res);
    check({tag, "_rv_cycle"},   rv_cyc,   (n == 0) ? 2 : n + 5);
    check({tag, "_busy_cyc"},   bcount,   (n == 0) ? 1 : n + 4);
    check({tag, "_valid_cnt"},  vcount,   (n == 0) ? 0 : n + 2);
    check({tag, "_valid_first"}, first_v, (n == 0) ? -1 : 2);
    check({tag, "_valid_last"}, last_v,   (n == 0) ? -1 : n + 3);
    check({tag, "_valid_split"}, split,   0);
    check({tag, "_w_reads"},    wr,       n);
    check({tag, "_x_reads"},    xr,       n);
    check({tag, "_addr_seq"},   addr_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [RW-1:0] e;
    int pulses;
    bus.start  = 1'b0;
    bus.length = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",    bus.busy,         0);
    check("rst_rv",      bus.result_valid, 0);
    check("rst_result",  bus.result,       0);
    check("rst_valid",   {bus.a_valid, bus.b_valid, bus.c_valid, bus.d_valid}, 0);
    check("rst_rd_en",   {bus.w_rd_en, bus.x_rd_en}, 0);
    check("rst_operand", {bus.a, bus.b, bus.d}, 0);
    check("rst_c",       bus.c,            0);
    reset = 1'b0;
    @(negedge clk);

    // N=1
    wmem[0] = 16'd3; xmem[0] = 16'd5;
    run_job("n1", 1, 1'b0, e);
    check("n1_const", bus.result, 15);
    @(negedge clk);

    // N=4
    for (int k = 0; k < 4; k++) begin
      wmem[k] = NB'(k + 1);
      xmem[k] = NB'(10 * (k + 1));
    end
    run_job("n4", 4, 1'b0, e);
    check("n4_const", bus.result, 300);
    repeat (3) @(negedge clk);
    check("n4_hold", bus.result, 300);

    // N=0: forced zero, no reads, no MAC transfers
    run_job("n0", 0, 1'b0, e);
    check("n0_const", bus.result, 0);
    @(negedge clk);

    // N=2 full-scale operands wrap modulo 2^32
    wmem[0] = 16'hFFFF; wmem[1] = 16'hFFFF;
    xmem[0] = 16'hFFFF; xmem[1] = 16'hFFFF;
    run_job("wrap", 2, 1'b0, e);
    check("wrap_const", bus.result, 32'hFFFC_0002);
    @(negedge clk);

    // Reset during STREAM of an N=8 job
    fill_random(8);
    bus.start  = 1'b1;
    bus.length = LW'(8);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_streaming", bus.a_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_valid",  {bus.a_valid, bus.b_valid, bus.c_valid, bus.d_valid}, 0);
    check("midrst_busy",   bus.busy,   0);
    check("midrst_rd_en",  {bus.w_rd_en, bus.x_rd_en}, 0);
    check("midrst_result", bus.result, 0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (bus.result_valid || bus.busy) pulses++;
      @(negedge clk);
    end
    check("midrst_no_pulse", pulses, 0);

    // Stale MAC registers from the aborted job must not leak in
    wmem[0] = 16'd7; wmem[1] = 16'd1;
    xmem[0] = 16'd6; xmem[1] = 16'd2;
    run_job("post_rst", 2, 1'b0, e);
    check("post_rst_const", bus.result, 44);
    @(negedge clk);

    // start held high: busy-time requests ignored, back-to-back acceptance
    for (int k = 0; k < 3; k++) begin
      wmem[k] = 16'd1;
      xmem[k] = 16'd2;
    end
    run_job("held1", 3, 1'b1, e);
    check("held1_const", bus.result, 6);
    run_job("held2", 3, 1'b1, e);
    check("held2_const", bus.result, 6);
    bus.start = 1'b0;
    @(negedge clk);

    // Random jobs
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 40);
      fill_random(n);
      run_job($sformatf("rand%0d", r), n, 1'b0, e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Requested length above the memory depth saturates to the full depth
    fill_random(DEPTH);
    run_job("sat", 1500, 1'b0, e);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
